alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
Round-robin controller that shares one combinational ALU (A, B, 3-bit ALUOp, C) between two requesters. It accepts one operation at a time over a valid/ready handshake and registers the operands onto the ALU inputs. It then samples the ALU result and returns it on a single response channel tagged with the requester id. It sits between two client datapaths and the single ALU instance.

Parameters:
WIDTH, 32, operand/result width; matches ALU A/B/C.
OPW, 3, ALU opcode width.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
req0_valid  in  1  requester 0 has an operation.
req0_ready  out  1  requester 0 operation accepted this cycle when valid && ready.
req0_a  in  WIDTH  requester 0 operand A.
req0_b  in  WIDTH  requester 0 operand B.
req0_op  in  OPW  requester 0 opcode.
req1_valid / req1_ready / req1_a / req1_b / req1_op  same as requester 0.
resp_valid  out  1  result available.
resp_ready  in  1  consumer takes result.
resp_id  out  1  requester that issued the result.
resp_data  out  WIDTH  ALU result; 0 on error.
resp_err  out  1  opcode was illegal (6 or 7).
alu_a  out  WIDTH  to ALU A.
alu_b  out  WIDTH  to ALU B.
alu_op  out  OPW  to ALU ALUOp.
alu_c  in  WIDTH  from ALU C (combinational).
busy  out  1  state != IDLE.

Behaviour:
- ALU opcodes: 0 add, 1 sub, 2 and, 3 or, 4 A>>B logical, 5 A>>>B arithmetic. 6 and 7 are illegal.
- Reset (async, rst_n=0): state=IDLE, last_grant=1 (requester 0 wins first), req*_ready=0, resp_valid=0, resp_id=0, resp_data=0, resp_err=0, alu_a=alu_b=0, alu_op=0, busy=0. Reset asserted in any state aborts the operation in flight with no response.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - grant = the valid requester when only one is valid.
  - When both are valid, grant = requester != last_grant.
  - reqN_ready = (state==IDLE) && grant==N. Ready is combinational from the valids, and at most one ready is high.
  - On handshake: latch a/b/op into alu_a/alu_b/alu_op, latch id, set last_grant=id.
  - Next state: EXEC for a legal op. For an illegal op, go straight to RESP with resp_err=1 and resp_data=0; the ALU outputs still load but are ignored.
- EXEC (exactly 1 cycle): alu_* are held stable. At the clock edge, resp_data<=alu_c, resp_err<=0, resp_id<=latched id, and the FSM moves to RESP.
- RESP:
  - resp_valid=1. resp_data, resp_id and resp_err are held stable until resp_ready=1.
  - On resp_valid && resp_ready the FSM returns to IDLE. resp_valid falls next cycle; resp_data keeps its last value.
  - No request is accepted in EXEC or RESP; both readies are 0.
- Latency: accept at edge T, EXEC in cycle T+1, resp_valid from cycle T+2. With resp_ready held at 1, the next accept happens in cycle T+3, giving a 3-cycle throughput.
- alu_a/alu_b/alu_op are registers and change only on accept.
- Width rule: the result is the ALU's WIDTH-bit C. No overflow flag; add/sub wrap modulo 2^WIDTH.
- A requester that drops valid before being granted loses nothing; the arbiter holds no pending state for it.
- Fairness: with both requesters continuously valid, grants strictly alternate 0,1,0,1.

Test Plan:
- Single op: req0 a=0x0000f001 b=0x00000004, ops 0..5 issued in turn, resp_ready=1 -> resp_data = 0x0000f005, 0x0000effd, 0x00000000, 0x0000f005, 0x00000f00, 0x00000f00. Each result has resp_id=0, resp_err=0 and resp_valid exactly 2 cycles after accept.
- Arithmetic shift: req1 a=0x80000000 b=4 op=5 -> resp_data=0xf8000000, resp_id=1. Then op=4 with the same operands -> 0x08000000.
- Contention: both valid in the first cycle after reset, req0 add 1+2, req1 sub 5-7 -> req0 granted first (resp 0x00000003, id 0), then req1 (resp 0xfffffffe, id 1). Accepts are 3 cycles apart and grants alternate across 4 back-to-back pairs.
- Backpressure: resp_ready=0 for 5 cycles during RESP -> resp_valid, resp_data and resp_id stable, both readies 0, busy=1. Raising resp_ready gives IDLE on the next cycle.
- Illegal op: req0 op=7 -> resp_err=1, resp_data=0, resp_valid in the cycle after accept (no EXEC cycle).
- Reset mid-operation: pull rst_n low during EXEC -> all outputs 0 immediately, no response emitted. After release, req0 wins the first contention.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// One operation in flight; the result returns on a single response channel tagged with the requester id.
module alu_arbiter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned OPW   = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OPW-1:0]   req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OPW-1:0]   req1_op,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_data,
    output logic             resp_err,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_op,
    input  logic [WIDTH-1:0] alu_c,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [OPW-1:0] OP_FIRST_ILLEGAL = OPW'(6);

    state_t             r_state;
    state_t             w_next_state;
    logic               r_last_grant;
    logic               r_id;
    logic [WIDTH-1:0]   r_alu_a;
    logic [WIDTH-1:0]   r_alu_b;
    logic [OPW-1:0]     r_alu_op;
    logic [WIDTH-1:0]   r_resp_data;
    logic               r_resp_err;
    logic               r_resp_id;

    logic               w_grant;
    logic               w_accept;
    logic [WIDTH-1:0]   w_sel_a;
    logic [WIDTH-1:0]   w_sel_b;
    logic [OPW-1:0]     w_sel_op;
    logic               w_illegal;

    // Grant the lone valid requester, or the one that did not win last time.
    always_comb begin
        w_grant = 1'b0;
        if (req0_valid && req1_valid) begin
            w_grant = ~r_last_grant;
        end else begin
            w_grant = req1_valid;
        end
    end

    assign w_accept   = rst_n && (r_state == S_IDLE) && (req0_valid || req1_valid);
    assign req0_ready = w_accept && !w_grant;
    assign req1_ready = w_accept && w_grant;

    assign w_sel_a   = w_grant ? req1_a  : req0_a;
    assign w_sel_b   = w_grant ? req1_b  : req0_b;
    assign w_sel_op  = w_grant ? req1_op : req0_op;
    assign w_illegal = (w_sel_op >= OP_FIRST_ILLEGAL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Illegal opcodes skip the ALU cycle and respond immediately with an error.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next_state = w_illegal ? S_RESP : S_EXEC;
                end
            end
            S_EXEC: w_next_state = S_RESP;
            S_RESP: begin
                if (resp_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= 1'b1;
            r_id         <= 1'b0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_op     <= '0;
            r_resp_data  <= '0;
            r_resp_err   <= 1'b0;
            r_resp_id    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_alu_a      <= w_sel_a;
                r_alu_b      <= w_sel_b;
                r_alu_op     <= w_sel_op;
                r_id         <= w_grant;
                r_last_grant <= w_grant;
                if (w_illegal) begin
                    r_resp_data <= '0;
                    r_resp_err  <= 1'b1;
                    r_resp_id   <= w_grant;
                end
            end
            if (r_state == S_EXEC) begin
                r_resp_data <= alu_c;
                r_resp_err  <= 1'b0;
                r_resp_id   <= r_id;
            end
        end
    end

    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_op     = r_alu_op;
    assign resp_data  = r_resp_data;
    assign resp_err   = r_resp_err;
    assign resp_id    = r_resp_id;
    assign resp_valid = (r_state == S_RESP);
    assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized scoreboard bench for alu_arbiter; a behavioural ALU drives alu_c.
// Expected responses are queued at accept and checked by an independent monitor.
module tb_alu_arbiter;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned OPW   = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req0_valid, req1_valid;
    logic             req0_ready, req1_ready;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [OPW-1:0]   req0_op, req1_op;
    logic             resp_valid, resp_ready, resp_id, resp_err, busy;
    logic [WIDTH-1:0] resp_data, alu_a, alu_b, alu_c;
    logic [OPW-1:0]   alu_op;

    typedef struct {
        logic        id;
        logic [31:0] data;
        logic        err;
        int unsigned cyc;
    } exp_t;

    exp_t        q[$];
    int unsigned cyc = 0;
    int unsigned free_cyc = 0;
    int          errors = 0;
    int          checks = 0;
    logic        last;
    logic        acc_any, acc_id;
    logic        gap_on = 1'b0;
    logic        have_prev = 1'b0;
    int unsigned prev_acc_cyc = 0;
    logic        m_prev;
    logic [31:0] m_data;
    logic        m_id, m_err;

    alu_arbiter #(.WIDTH(WIDTH), .OPW(OPW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_data(resp_data), .resp_err(resp_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_c(alu_c),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] op);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a >> b;
            3'd5:    return 32'($signed(a) >>> b);
            default: return 32'h0;
        endcase
    endfunction

    assign alu_c = ref_alu(alu_a, alu_b, alu_op);

    function automatic logic [31:0] rand_b();
        if ($urandom_range(0, 3) == 0) return $urandom;
        return 32'($urandom_range(0, 31));
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_flags"}, 64'({resp_valid, resp_id, resp_err, busy, req0_ready, req1_ready}), 64'(0));
        chk({name, "_data"}, 64'(resp_data), 64'(0));
        chk({name, "_alu"}, {alu_a, alu_b} | 64'(alu_op), 64'(0));
    endtask

    task automatic accept(input logic id, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] op);
        exp_t e;
        e.id   = id;
        e.err  = (op >= 3'd6);
        e.data = e.err ? 32'h0 : ref_alu(a, b, op);
        e.cyc  = cyc + (e.err ? 1 : 2);
        q.push_back(e);
        last    = id;
        acc_any = 1'b1;
        acc_id  = id;
        if (gap_on && have_prev) chk("accept_gap", 64'(cyc - prev_acc_cyc), 64'(3));
        prev_acc_cyc = cyc;
        have_prev    = 1'b1;
    endtask

    // One cycle: check readies against the arbitration rules, record any accept.
    task automatic step();
        logic idle, g, e0, e1;
        @(negedge clk);
        acc_any = 1'b0;
        idle = (q.size() == 0) && (cyc >= free_cyc);
        g  = (req0_valid && req1_valid) ? !last : req1_valid;
        e0 = idle && req0_valid && !g;
        e1 = idle && req1_valid && g;
        chk("readies", 64'({req0_ready, req1_ready}), 64'({e0, e1}));
        if (req0_valid && req0_ready) accept(1'b0, req0_a, req0_b, req0_op);
        else if (req1_valid && req1_ready) accept(1'b1, req1_a, req1_b, req1_op);
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic id, input logic v, input logic [31:0] a,
                           input logic [31:0] b, input logic [2:0] op);
        if (id) begin
            req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
        end else begin
            req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
        end
    endtask

    task automatic issue(input logic id, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op);
        logic got;
        got = 1'b0;
        set_req(id, 1'b1, a, b, op);
        for (int i = 0; i < 40 && !got; i++) begin
            step();
            if (acc_any && acc_id == id) got = 1'b1;
        end
        set_req(id, 1'b0, a, b, op);
        if (!got) chk("issue_timeout", 64'(got), 64'(1));
    endtask

    task automatic drain();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        resp_ready = 1'b1;
        for (int i = 0; i < 20 && q.size() != 0; i++) step();
        if (q.size() != 0) chk("drain_timeout", 64'(q.size()), 64'(0));
        step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        q.delete();
        last      = 1'b1;
        have_prev = 1'b0;
        #1;
        chk_zero("reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: checks latency, hold-under-backpressure and payload of every response.
    initial begin : monitor
        m_prev = 1'b0;
        m_data = '0;
        m_id   = 1'b0;
        m_err  = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n || !resp_valid) begin
                m_prev = 1'b0;
            end else if (q.size() == 0) begin
                chk("unexpected_resp", 64'(resp_valid), 64'(0));
            end else begin
                if (!m_prev) begin
                    chk("resp_latency", 64'(cyc), 64'(q[0].cyc));
                end else begin
                    chk("hold_data", 64'(resp_data), 64'(m_data));
                    chk("hold_id_err", 64'({resp_id, resp_err}), 64'({m_id, m_err}));
                end
                chk("resp_busy", 64'(busy), 64'(1));
                if (resp_ready) begin
                    chk("resp_id", 64'(resp_id), 64'(q[0].id));
                    chk("resp_data", 64'(resp_data), 64'(q[0].data));
                    chk("resp_err", 64'(resp_err), 64'(q[0].err));
                    void'(q.pop_front());
                    free_cyc = cyc + 1;
                    m_prev   = 1'b0;
                end else begin
                    chk("bp_readies", 64'({req0_ready, req1_ready}), 64'(0));
                    m_prev = 1'b1;
                    m_data = resp_data;
                    m_id   = resp_id;
                    m_err  = resp_err;
                end
            end
        end
    end

    initial begin : stimulus
        logic [31:0] held;
        logic        seen;
        int          n;
        rst_n = 1'b1;
        resp_ready = 1'b1;
        set_req(1'b0, 1'b0, '0, '0, '0);
        set_req(1'b1, 1'b0, '0, '0, '0);
        last = 1'b1;
        #1;
        do_reset();

        // Directed single ops from requester 0, then arithmetic vs logical shift from requester 1.
        for (int op = 0; op < 6; op++) issue(1'b0, 32'h0000f001, 32'h4, 3'(op));
        issue(1'b1, 32'h80000000, 32'h4, 3'd5);
        issue(1'b1, 32'h80000000, 32'h4, 3'd4);
        drain();

        // Contention straight out of reset: grants alternate, accepts 3 cycles apart.
        @(posedge clk);
        #1;
        do_reset();
        set_req(1'b0, 1'b1, 32'd1, 32'd2, 3'd0);
        set_req(1'b1, 1'b1, 32'd5, 32'd7, 3'd1);
        gap_on = 1'b1;
        n = 0;
        for (int i = 0; i < 40 && n < 8; i++) begin
            step();
            if (acc_any) begin
                chk("contend_id", 64'(acc_id), 64'(n % 2));
                n++;
                set_req(acc_id, 1'b1, $urandom, rand_b(), 3'($urandom_range(0, 5)));
            end
        end
        chk("contend_count", 64'(n), 64'(8));
        gap_on = 1'b0;
        drain();

        // Backpressure: response held for 5 cycles with requester 1 waiting.
        resp_ready = 1'b0;
        issue(1'b0, 32'h12345678, 32'h00000fff, 3'd2);
        set_req(1'b1, 1'b1, 32'h1, 32'h1, 3'd0);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            seen = resp_valid;
        end
        chk("bp_resp_seen", 64'(seen), 64'(1));
        repeat (5) step();
        chk("bp_busy", 64'(busy), 64'(1));
        held = ref_alu(32'h12345678, 32'h00000fff, 3'd2);
        resp_ready = 1'b1;
        step();
        chk("bp_idle_after", 64'({busy, resp_valid}), 64'(0));
        chk("bp_data_kept", 64'(resp_data), 64'(held));
        issue(1'b1, 32'h1, 32'h1, 3'd0);
        drain();

        // Illegal opcodes skip the ALU cycle.
        issue(1'b0, 32'hdeadbeef, 32'h1, 3'd7);
        issue(1'b1, 32'h1, 32'h2, 3'd6);
        drain();

        // Reset during EXEC: no response, and requester 0 wins afterwards.
        issue(1'b0, 32'h11, 32'h22, 3'd0);
        chk("exec_busy", 64'(busy), 64'(1));
        do_reset();
        set_req(1'b0, 1'b1, 32'h3, 32'h4, 3'd3);
        set_req(1'b1, 1'b1, 32'h5, 32'h6, 3'd0);
        step();
        chk("post_reset_grant", 64'({acc_any, acc_id}), 64'(2'b10));
        set_req(1'b0, 1'b0, '0, '0, '0);
        issue(1'b1, 32'h5, 32'h6, 3'd0);
        drain();

        // Randomized traffic with random backpressure.
        for (int i = 0; i < 400; i++) begin
            set_req(1'b0, $urandom_range(0, 2) != 0, $urandom, rand_b(), 3'($urandom_range(0, 7)));
            set_req(1'b1, $urandom_range(0, 2) != 0, $urandom, rand_b(), 3'($urandom_range(0, 7)));
            resp_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
